// File: rtl/fmv_macroblock_writer_pkg.sv
// Shared FMV types: frame descriptor, DDR core base, writer FSM encodings.
// Imported by the macroblock writer and its row address generator.
package fmv_macroblock_writer_pkg;

  localparam logic [3:0] FMV_DDR_CORE_BASE = 4'b0011;

  typedef struct packed {
    logic [28:0] y_adr;
    logic [28:0] u_adr;
    logic [28:0] v_adr;
  } planar_yuv_s;

  typedef enum logic [1:0] {
    PL_Y,
    PL_U,
    PL_V
  } plane_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WRITE,
    ST_DONE
  } wr_state_e;

  function automatic logic [1:0] burst_len(plane_e p);
    return (p == PL_Y) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [3:0] last_row(plane_e p);
    return (p == PL_Y) ? 4'd15 : 4'd7;
  endfunction

endpackage

// File: rtl/ddr_if.sv
// DDR host port: one requester drives a write burst, the memory side
// returns busy as backpressure.
interface ddr_if;
  logic        acquire;
  logic        read;
  logic        write;
  logic [28:0] addr;
  logic [7:0]  burstcnt;
  logic [63:0] wdata;
  logic [7:0]  byteenable;
  logic        busy;

  modport to_host (
    output acquire, read, write, addr,
    output burstcnt, wdata, byteenable,
    input  busy
  );

  modport to_ddr (
    input  acquire, read, write, addr,
    input  burstcnt, wdata, byteenable,
    output busy
  );
endinterface

// File: rtl/fmv_macroblock_writer_row_address.sv
// Registered byte address of one macroblock row in a Y, U or V plane.
// Chroma planes use half the luma stride and 8-pixel columns.
module mb_row_address
  import fmv_macroblock_writer_pkg::*;
(
  input  logic        clkddr,
  input  logic        reset_n,
  input  plane_e      plane,
  input  logic [5:0]  mb_x,
  input  logic [4:0]  mb_y,
  input  logic [3:0]  row,
  input  logic [10:0] stride,
  input  planar_yuv_s frame,
  output logic [28:0] byte_addr
);

  logic [8:0]  line;
  logic [10:0] pitch;
  logic [9:0]  col;
  logic [28:0] base;
  logic [19:0] prod;
  logic [28:0] sum;

  always_comb begin
    line  = '0;
    pitch = '0;
    col   = '0;
    base  = '0;
    unique case (1'b1)
      (plane == PL_Y): begin
        line  = {mb_y, 4'b0} + {5'b0, row};
        pitch = stride;
        col   = {mb_x, 4'b0};
        base  = frame.y_adr;
      end
      (plane == PL_U): begin
        line  = {1'b0, mb_y, 3'b0} + {5'b0, row};
        pitch = {1'b0, stride[10:1]};
        col   = {1'b0, mb_x, 3'b0};
        base  = frame.u_adr;
      end
      default: begin
        line  = {1'b0, mb_y, 3'b0} + {5'b0, row};
        pitch = {1'b0, stride[10:1]};
        col   = {1'b0, mb_x, 3'b0};
        base  = frame.v_adr;
      end
    endcase
    prod = {11'b0, line} * {9'b0, pitch};
    sum  = base + {9'b0, prod} + {19'b0, col};
  end

  always_ff @(posedge clkddr or negedge reset_n) begin
    if (!reset_n) byte_addr <= '0;
    else          byte_addr <= sum;
  end

endmodule

// File: rtl/fmv_macroblock_writer.sv
// Writes one decoded macroblock (16 Y rows, 8 U rows, 8 V rows of 64-bit
// words) into the planar YUV frame buffer over the DDR host port.
module fmv_macroblock_writer
  import fmv_macroblock_writer_pkg::*;
#(
  parameter logic [3:0] DDR_CORE_BASE = FMV_DDR_CORE_BASE
) (
  input  logic        clkddr,
  input  logic        reset_n,
  ddr_if.to_host      ddrif,
  input  planar_yuv_s frame,
  input  logic [10:0] frame_stride,
  input  logic [5:0]  mb_x,
  input  logic [4:0]  mb_y,
  input  logic        mb_start,
  input  logic [63:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        mb_busy,
  output logic        mb_done
);

  wr_state_e   state, state_nxt;
  plane_e      plane;
  logic [3:0]  row;
  logic [1:0]  taken, beat;
  planar_yuv_s frame_q;
  logic [10:0] stride_q;
  logic [5:0]  mb_x_q;
  logic [4:0]  mb_y_q;
  logic [28:0] byte_addr;

  logic        write_q, acquire_q;
  logic [28:0] addr_q;
  logic [7:0]  burstcnt_q;
  logic [63:0] wdata_q;

  logic in_acc, beat_acc, row_end, plane_end;
  logic unused_addr_bits;

  mb_row_address u_row_addr (
    .clkddr    (clkddr),
    .reset_n   (reset_n),
    .plane     (plane),
    .mb_x      (mb_x_q),
    .mb_y      (mb_y_q),
    .row       (row),
    .stride    (stride_q),
    .frame     (frame_q),
    .byte_addr (byte_addr)
  );

  assign unused_addr_bits = ^{byte_addr[28], byte_addr[2:0]};

  assign beat_acc  = write_q && !ddrif.busy;
  assign row_end   = beat_acc && (beat == burst_len(plane) - 2'd1);
  assign plane_end = (row == last_row(plane));
  assign in_acc    = pix_valid && pix_ready;

  always_ff @(posedge clkddr or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (mb_start) state_nxt = ST_ADDR;
      ST_ADDR:  state_nxt = ST_WRITE;
      ST_WRITE: if (row_end)
                  state_nxt = (plane_end && plane == PL_V) ?
                              ST_DONE : ST_ADDR;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Only take as many words as the current row still needs.
  always_comb begin
    pix_ready = (state == ST_WRITE) &&
                (!write_q || !ddrif.busy) &&
                (taken != burst_len(plane));
    mb_busy   = (state != ST_IDLE);
    mb_done   = (state == ST_DONE);
  end

  always_ff @(posedge clkddr or negedge reset_n) begin
    if (!reset_n) begin
      plane      <= PL_Y;
      row        <= '0;
      taken      <= '0;
      beat       <= '0;
      frame_q    <= '0;
      stride_q   <= '0;
      mb_x_q     <= '0;
      mb_y_q     <= '0;
      write_q    <= 1'b0;
      acquire_q  <= 1'b0;
      addr_q     <= '0;
      burstcnt_q <= '0;
      wdata_q    <= '0;
    end else begin
      if (state == ST_IDLE && mb_start) begin
        frame_q  <= frame;
        stride_q <= frame_stride;
        mb_x_q   <= mb_x;
        mb_y_q   <= mb_y;
        row      <= '0;
        plane    <= PL_Y;
      end
      if (state == ST_ADDR) begin
        taken <= '0;
        beat  <= '0;
      end
      if (in_acc) begin
        write_q <= 1'b1;
        wdata_q <= pix_data;
        taken   <= taken + 2'd1;
        if (taken == 2'd0) begin
          addr_q     <= {DDR_CORE_BASE, byte_addr[27:3]};
          burstcnt_q <= {6'b0, burst_len(plane)};
          acquire_q  <= 1'b1;
        end
      end else if (beat_acc) begin
        write_q <= 1'b0;
      end
      if (beat_acc) beat <= beat + 2'd1;
      if (row_end) begin
        if (!plane_end) begin
          row <= row + 4'd1;
        end else begin
          row   <= '0;
          plane <= (plane == PL_Y) ? PL_U : PL_V;
          if (plane == PL_V) acquire_q <= 1'b0;
        end
      end
    end
  end

  assign ddrif.acquire    = acquire_q;
  assign ddrif.read       = 1'b0;
  assign ddrif.write      = write_q;
  assign ddrif.addr       = addr_q;
  assign ddrif.burstcnt   = burstcnt_q;
  assign ddrif.wdata      = wdata_q;
  assign ddrif.byteenable = 8'hff;

endmodule
